// File: rtl/cmd_frame_decoder.sv
// cmd_frame_decoder: assembles multi-byte command frames from the synchronized
// RX byte stream and issues single-cycle register-file / ALU strobes.
// An inter-byte timeout aborts truncated frames back to IDLE.
module cmd_frame_decoder #(
  parameter int unsigned          BUS_WIDTH   = 8,
  parameter int unsigned          ADDR_WIDTH  = 4,
  parameter int unsigned          FUN_WIDTH   = 4,
  parameter int unsigned          TIMEOUT     = 255,
  parameter logic [BUS_WIDTH-1:0] CMD_WR      = 8'hAA,
  parameter logic [BUS_WIDTH-1:0] CMD_RD      = 8'hBB,
  parameter logic [BUS_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [BUS_WIDTH-1:0] CMD_ALU_NOP = 8'hDD
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [BUS_WIDTH-1:0]  rx_data,
  input  logic                  rx_valid,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [BUS_WIDTH-1:0]  rf_wr_data,
  output logic                  alu_en,
  output logic [BUS_WIDTH-1:0]  alu_op_a,
  output logic [BUS_WIDTH-1:0]  alu_op_b,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_ALU_A   = 3'd4;
  localparam logic [2:0] S_ALU_B   = 3'd5;
  localparam logic [2:0] S_ALU_FUN = 3'd6;
  localparam logic [2:0] S_NOP_FUN = 3'd7;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  alu_en_q, alu_en_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0]  op_a_q, op_a_d;
  logic [BUS_WIDTH-1:0]  op_b_q, op_b_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;

  assign cnt_inc = cnt_q + 1'b1;

  // Next-state, field latching, strobe generation and inter-byte timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    alu_en_d = 1'b0;
    err_d    = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    fun_d    = fun_q;

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (rx_valid) begin
        if (rx_data == CMD_WR)           state_d = S_WR_ADDR;
        else if (rx_data == CMD_RD)      state_d = S_RD_ADDR;
        else if (rx_data == CMD_ALU_OP)  state_d = S_ALU_A;
        else if (rx_data == CMD_ALU_NOP) state_d = S_NOP_FUN;
        else                             err_d   = 1'b1;
      end
    end else if (rx_valid) begin
      cnt_d = '0;
      case (state_q)
        S_WR_ADDR: begin
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          state_d = S_WR_DATA;
        end
        S_WR_DATA: begin
          wdata_d = rx_data;
          wr_en_d = 1'b1;
          state_d = S_IDLE;
        end
        S_RD_ADDR: begin
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = S_IDLE;
        end
        S_ALU_A: begin
          op_a_d  = rx_data;
          state_d = S_ALU_B;
        end
        S_ALU_B: begin
          op_b_d  = rx_data;
          state_d = S_ALU_FUN;
        end
        default: begin
          fun_d    = rx_data[FUN_WIDTH-1:0];
          alu_en_d = 1'b1;
          state_d  = S_IDLE;
        end
      endcase
    end else if (cnt_inc == TIMEOUT_C) begin
      // Abort on the stall cycle that brings the count to TIMEOUT; the counter
      // never holds TIMEOUT itself, so it cannot wrap.
      err_d   = 1'b1;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      alu_en_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      fun_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      alu_en_q <= alu_en_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      fun_q    <= fun_d;
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_rd_en   = rd_en_q;
  assign rf_addr    = addr_q;
  assign rf_wr_data = wdata_q;
  assign alu_en     = alu_en_q;
  assign alu_op_a   = op_a_q;
  assign alu_op_b   = op_b_q;
  assign alu_fun    = fun_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed testbench for cmd_frame_decoder (TIMEOUT overridden to 8).
module tb_cmd_frame_decoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rf_wr_en, rf_rd_en, alu_en, frame_err, busy;
  logic [3:0] rf_addr, alu_fun;
  logic [7:0] rf_wr_data, alu_op_a, alu_op_b;

  int checks = 0;
  int errors = 0;

  cmd_frame_decoder #(
    .BUS_WIDTH (8),
    .ADDR_WIDTH(4),
    .FUN_WIDTH (4),
    .TIMEOUT   (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rf_wr_en  (rf_wr_en),
    .rf_rd_en  (rf_rd_en),
    .rf_addr   (rf_addr),
    .rf_wr_data(rf_wr_data),
    .alu_en    (alu_en),
    .alu_op_a  (alu_op_a),
    .alu_op_b  (alu_op_b),
    .alu_fun   (alu_fun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the edge that
  // captured the byte, so registered results of that byte are visible.
  task automatic drive(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk_strobes(input string tag, input logic [3:0] exp_wr_rd_alu_err);
    chk({tag, "_wr"},  32'(rf_wr_en),  32'(exp_wr_rd_alu_err[3]));
    chk({tag, "_rd"},  32'(rf_rd_en),  32'(exp_wr_rd_alu_err[2]));
    chk({tag, "_alu"}, 32'(alu_en),    32'(exp_wr_rd_alu_err[1]));
    chk({tag, "_err"}, 32'(frame_err), 32'(exp_wr_rd_alu_err[0]));
  endtask

  task automatic chk_all_zero(input string tag);
    chk_strobes(tag, 4'b0000);
    chk({tag, "_busy"}, 32'(busy),       32'h0);
    chk({tag, "_addr"}, 32'(rf_addr),    32'h0);
    chk({tag, "_wdat"}, 32'(rf_wr_data), 32'h0);
    chk({tag, "_a"},    32'(alu_op_a),   32'h0);
    chk({tag, "_b"},    32'(alu_op_b),   32'h0);
    chk({tag, "_fun"},  32'(alu_fun),    32'h0);
  endtask

  initial begin
    RST      = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    idle(2);
    chk_all_zero("reset");
    RST = 1'b1;
    idle(1);

    // Write frame, one byte every 4 cycles
    drive(8'hAA);
    chk("wr_busy_after_cmd", 32'(busy), 32'h1);
    idle(3);
    drive(8'h05);
    idle(3);
    drive(8'h3C);
    chk_strobes("wr_done", 4'b1000);
    chk("wr_addr", 32'(rf_addr), 32'h5);
    chk("wr_data", 32'(rf_wr_data), 32'h3C);
    chk("wr_busy_fall", 32'(busy), 32'h0);
    idle(1);
    chk_strobes("wr_after", 4'b0000);

    // Read frame with address upper bit dropped
    drive(8'hBB);
    drive(8'h1F);
    chk_strobes("rd_done", 4'b0100);
    chk("rd_addr", 32'(rf_addr), 32'hF);
    chk("rd_wdata_held", 32'(rf_wr_data), 32'h3C);
    idle(1);
    chk_strobes("rd_after", 4'b0000);

    // ALU op frame followed back-to-back by NOP frame
    drive(8'hCC);
    drive(8'h12);
    drive(8'h34);
    drive(8'h07);
    chk_strobes("alu_done", 4'b0010);
    chk("alu_a", 32'(alu_op_a), 32'h12);
    chk("alu_b", 32'(alu_op_b), 32'h34);
    chk("alu_fun", 32'(alu_fun), 32'h7);
    drive(8'hDD);
    chk_strobes("nop_cmd", 4'b0000);
    chk("nop_busy", 32'(busy), 32'h1);
    drive(8'h02);
    chk_strobes("nop_done", 4'b0010);
    chk("nop_a", 32'(alu_op_a), 32'h12);
    chk("nop_b", 32'(alu_op_b), 32'h34);
    chk("nop_fun", 32'(alu_fun), 32'h2);
    idle(1);
    chk_strobes("nop_after", 4'b0000);

    // Unknown command byte, then a normal write frame
    drive(8'h55);
    chk_strobes("unk_err", 4'b0001);
    chk("unk_busy", 32'(busy), 32'h0);
    idle(1);
    chk_strobes("unk_after", 4'b0000);
    drive(8'hAA);
    drive(8'h01);
    drive(8'h99);
    chk_strobes("unk_wr_done", 4'b1000);
    chk("unk_wr_addr", 32'(rf_addr), 32'h1);
    chk("unk_wr_data", 32'(rf_wr_data), 32'h99);

    // Timeout after 8 stalled cycles; latched address stays
    drive(8'hAA);
    drive(8'h05);
    idle(7);
    chk_strobes("to_pre", 4'b0000);
    chk("to_pre_busy", 32'(busy), 32'h1);
    idle(1);
    chk_strobes("to_err", 4'b0001);
    chk("to_busy", 32'(busy), 32'h0);
    chk("to_addr_kept", 32'(rf_addr), 32'h5);
    chk("to_wdata_kept", 32'(rf_wr_data), 32'h99);
    idle(1);
    chk_strobes("to_after", 4'b0000);

    // Final byte on exactly the 8th stalled cycle wins
    drive(8'hAA);
    drive(8'h06);
    idle(7);
    drive(8'h77);
    chk_strobes("to_edge_wr", 4'b1000);
    chk("to_edge_addr", 32'(rf_addr), 32'h6);
    chk("to_edge_data", 32'(rf_wr_data), 32'h77);
    idle(1);
    chk_strobes("to_edge_after", 4'b0000);

    // Asynchronous reset mid-frame
    drive(8'hCC);
    drive(8'h12);
    chk("mid_busy", 32'(busy), 32'h1);
    #2;
    RST = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    drive(8'hDD);
    drive(8'h03);
    chk_strobes("post_rst_nop", 4'b0010);
    chk("post_rst_a", 32'(alu_op_a), 32'h0);
    chk("post_rst_b", 32'(alu_op_b), 32'h0);
    chk("post_rst_fun", 32'(alu_fun), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
